i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
Synthesizable I2C initiator for the opposite end of the bus from the team's 16-bit-offset I2C target (7-bit device address, offset high byte, offset low byte, data).
Performs one single-byte register write or read per request. Drives SCL/SDA open-drain (drive-low / release only) and supports clock stretching.
Sits between a local control FSM and board-level tristate pads.

Parameters:
CLK_DIV, 4, clk cycles per quarter SCL bit-time (one bit = 4 quarters = 4*CLK_DIV clk); legal range 2..1023

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when busy=0
rw  input  1  0 = write, 1 = read; latched with start
dev_addr  input  7  target address; latched with start
offset  input  16  register offset; latched with start
wdata  input  8  write byte; latched with start
rdata  output  8  read byte; valid when done=1 for a read
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
ack_err  output  1  valid with done: 1 = target NACKed
scl_oe  output  1  1 = pull SCL low
sda_oe  output  1  1 = pull SDA low
scl_in  input  1  SCL pad level, for stretch detection
sda_in  input  1  SDA pad level

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, state=IDLE. No STOP is generated.
- Quarter timer counts CLK_DIV clk cycles. Each bit is quarters q0..q3:
  - q0, q1: SCL low; SDA changes only at q0 entry.
  - q2, q3: SCL released; SDA sampled on the last clk of q3.
- Clock stretching: in q2, the timer holds while scl_in=0. Quarter q2 begins counting once scl_in=1.
- States: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE.
- START (from idle):
  - q0, q1: SDA and SCL both released.
  - q2, q3: SDA low, SCL released.
  - The next bit's q0 pulls SCL low.
- RSTART:
  - q0: SCL low, SDA released.
  - q1: SCL released.
  - q2, q3: SDA low.
- STOP:
  - q0: SCL low, SDA low.
  - q1: SCL released.
  - q2, q3: SDA released.
- TX_BYTE: sends 8 bits MSB first, then RX_ACK releases SDA for one bit. sda_in=1 at the sample point means NACK.
- Write sequence: START, {dev_addr,0}, offset[15:8], offset[7:0], wdata, STOP. Total N=38 bit-times.
- Read sequence: START, {dev_addr,0}, offset[15:8], offset[7:0], RSTART, {dev_addr,1}, RX_BYTE, TX_NACK, STOP. Total N=48 bit-times.
- RX_BYTE: SDA released; shifts in sda_in MSB first. TX_NACK: SDA released for the ack bit.
- NACK on any RX_ACK: sets ack_err, proceeds directly to STOP and skips the remaining bytes. rdata is unchanged.
- Done timing: with no stretching, done is high in exactly cycle T+1+4*CLK_DIV*N, where T is the clk edge that accepts start.
  - busy falls in the same cycle done rises.
  - Stretching adds the held cycles.
- rdata updates only on a successful read, in the done cycle, and holds until the next successful read.
- start while busy=1 is ignored and not queued. start in the done cycle is ignored.
- A new transaction may be accepted in the cycle after done.
- The block never drives high; it only asserts *_oe.

Test Plan:
- Write, CLK_DIV=4, dev_addr=0x36, offset=0x1234, wdata=0xA5, target model ACKs all bytes -> bus bytes 0x6C, 0x12, 0x34, 0xA5; done at T+609; ack_err=0; target memory[0x1234]=0xA5.
- Read, offset=0x1234 preloaded with 0x5A -> bytes 0x6C, 0x12, 0x34, repeated START, 0x6D, master NACK, STOP; done at T+769; rdata=0x5A.
- dev_addr=0x35 (absent) -> NACK after first byte; STOP; done at T+1+16*(1+9+1); ack_err=1; rdata unchanged.
- Target holds SCL low 37 clk during q2 of bit 3 -> done delayed by exactly 37 cycles; data unchanged.
- start pulsed again while busy, and in the done cycle -> ignored; exactly one transaction on the bus.
- rst asserted mid-byte -> scl_oe=0 and sda_oe=0 asynchronously; busy=0; a subsequent write completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// I2C initiator: one single-byte write or read at a 16-bit register offset.
// Ports: clk/rst; start,rw,dev_addr,offset,wdata request; rdata,busy,done,
// ack_err status; scl_oe/sda_oe open-drain pulls; scl_in/sda_in pad levels.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  dev_addr,
    input  logic [15:0] offset,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in
);

    localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RSTART,
        S_RX_BYTE, S_TX_NACK, S_STOP, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [9:0]  cnt;
    logic [1:0]  q;
    logic [2:0]  bitn;
    logic [2:0]  byte_idx;
    logic        rw_r;
    logic [6:0]  addr_r;
    logic [15:0] off_r;
    logic [7:0]  wdata_r;
    logic [7:0]  txsh;
    logic [7:0]  rxsh;
    logic        nack;
    logic        active, hold, bit_end, accept;

    assign active  = (state != S_IDLE) && (state != S_DONE);
    // A target stretching the clock keeps SCL low after we release it.
    assign hold    = (q == 2'd2) && !scl_in;
    assign bit_end = active && !hold && (cnt == DIV_M1) && (q == 2'd3);
    // The done cycle is still IDLE, so gate on done to ignore start there.
    assign accept  = (state == S_IDLE) && start && !done;
    assign ack_err = nack;

    always_comb begin
        state_n = state;
        scl_oe  = 1'b0;
        sda_oe  = 1'b0;
        unique case (state)
            S_IDLE: if (accept) state_n = S_START;
            S_START: begin
                sda_oe = q[1];
                if (bit_end) state_n = S_TX_BYTE;
            end
            S_TX_BYTE: begin
                scl_oe = !q[1];
                sda_oe = !txsh[7];
                if (bit_end && bitn == 3'd7) state_n = S_RX_ACK;
            end
            S_RX_ACK: begin
                scl_oe = !q[1];
                if (bit_end) begin
                    if (sda_in || byte_idx == 3'd3)
                        state_n = S_STOP;
                    else if (byte_idx == 3'd4)
                        state_n = S_RX_BYTE;
                    else if (byte_idx == 3'd2 && rw_r)
                        state_n = S_RSTART;
                    else
                        state_n = S_TX_BYTE;
                end
            end
            S_RSTART: begin
                scl_oe = (q == 2'd0);
                sda_oe = q[1];
                if (bit_end) state_n = S_TX_BYTE;
            end
            S_RX_BYTE: begin
                scl_oe = !q[1];
                if (bit_end && bitn == 3'd7) state_n = S_TX_NACK;
            end
            S_TX_NACK: begin
                scl_oe = !q[1];
                if (bit_end) state_n = S_STOP;
            end
            S_STOP: begin
                scl_oe = (q == 2'd0);
                sda_oe = !q[1];
                if (bit_end) state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            q        <= '0;
            bitn     <= '0;
            byte_idx <= '0;
            rw_r     <= 1'b0;
            addr_r   <= '0;
            off_r    <= '0;
            wdata_r  <= '0;
            txsh     <= '0;
            rxsh     <= '0;
            nack     <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;

            if (!active) begin
                cnt <= '0;
                q   <= '0;
            end else if (!hold) begin
                if (cnt == DIV_M1) begin
                    cnt <= '0;
                    q   <= q + 2'd1;
                end else begin
                    cnt <= cnt + 10'd1;
                end
            end

            if (accept) begin
                rw_r    <= rw;
                addr_r  <= dev_addr;
                off_r   <= offset;
                wdata_r <= wdata;
                nack    <= 1'b0;
                busy    <= 1'b1;
            end

            if (bit_end) begin
                case (state)
                    S_START: begin
                        txsh     <= {addr_r, 1'b0};
                        bitn     <= '0;
                        byte_idx <= '0;
                    end
                    S_TX_BYTE: begin
                        txsh <= txsh << 1;
                        bitn <= bitn + 3'd1;
                    end
                    S_RX_ACK: begin
                        bitn     <= '0;
                        byte_idx <= byte_idx + 3'd1;
                        if (sda_in) nack <= 1'b1;
                        case (byte_idx)
                            3'd0: txsh <= off_r[15:8];
                            3'd1: txsh <= off_r[7:0];
                            3'd2: txsh <= wdata_r;
                            default: txsh <= txsh;
                        endcase
                    end
                    S_RSTART: begin
                        txsh     <= {addr_r, 1'b1};
                        byte_idx <= 3'd4;
                    end
                    S_RX_BYTE: begin
                        rxsh <= {rxsh[6:0], sda_in};
                        bitn <= bitn + 3'd1;
                    end
                    default: ;
                endcase
            end

            if (state == S_DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
                if (rw_r && !nack) rdata <= rxsh;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: 16-bit-offset target model on the bus,
// scoreboard queues for bus bytes and completion results.
module tb_i2c_master_ctrl;

    localparam int DIV = 4;
    localparam int BT  = 4 * DIV;
    localparam logic [6:0] TGT = 7'h36;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic [15:0] offset = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        busy, done, ack_err, scl_oe, sda_oe;
    logic        stretch = 1'b0;
    logic        tsda = 1'b0;
    logic        scl, sda;

    assign scl = !(scl_oe || stretch);
    assign sda = !(sda_oe || tsda);

    i2c_master_ctrl #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw),
        .dev_addr(dev_addr), .offset(offset), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
        .scl_oe(scl_oe), .sda_oe(sda_oe),
        .scl_in(scl), .sda_in(sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic       ack;
        logic [7:0] rd;
        int         t;
    } exp_t;

    exp_t       exp_done[$];
    logic [7:0] exp_bytes[$];
    exp_t       mon_e;

    // Completion monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_done.size() == 0) begin
                check("done_extra", {31'd0, done}, 32'd0);
            end else begin
                mon_e = exp_done.pop_front();
                check("ack_err", {31'd0, ack_err}, {31'd0, mon_e.ack});
                check("rdata", {24'd0, rdata}, {24'd0, mon_e.rd});
                check("done_cycle", cyc, mon_e.t);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Target model, sampled mid-cycle when the bus is settled
    typedef enum {P_IDLE, P_ADDR, P_OFFH, P_OFFL, P_DATA} ph_t;
    logic [7:0]  mem [0:65535];
    ph_t         ph = P_IDLE;
    int          bitcnt = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  txb = '0;
    logic [15:0] ptr = '0;
    bit          rd_pend = 1'b0;
    bit          rd_act = 1'b0;
    logic        pscl = 1'b1, psda = 1'b1;
    logic        cs, cd;

    always @(negedge clk) begin
        cs = scl;
        cd = sda;
        if (cs && pscl && psda && !cd) begin
            ph = P_ADDR; bitcnt = 0; rd_pend = 0; rd_act = 0; tsda = 0;
        end else if (cs && pscl && !psda && cd) begin
            ph = P_IDLE; rd_pend = 0; rd_act = 0; tsda = 0;
        end else if (ph != P_IDLE && cs && !pscl) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], cd};
                bitcnt++;
            end else begin
                if (rd_act) check("master_nack", {31'd0, cd}, 32'd1);
                bitcnt = 9;
            end
        end else if (ph != P_IDLE && !cs && pscl) begin
            if (bitcnt == 8 && rd_act) begin
                tsda = 0;
            end else if (bitcnt == 8) begin
                if (exp_bytes.size() == 0)
                    check("bus_byte_extra", {24'd0, sh}, 32'hFFFF);
                else
                    check("bus_byte", {24'd0, sh},
                          {24'd0, exp_bytes.pop_front()});
                case (ph)
                    P_ADDR:
                        if (sh[7:1] == TGT) begin
                            tsda = 1;
                            if (sh[0]) begin
                                rd_pend = 1;
                                txb = mem[ptr];
                            end else begin
                                ph = P_OFFH;
                            end
                        end else begin
                            tsda = 0;
                            ph = P_IDLE;
                        end
                    P_OFFH: begin ptr[15:8] = sh; tsda = 1; ph = P_OFFL; end
                    P_OFFL: begin ptr[7:0] = sh; tsda = 1; ph = P_DATA; end
                    P_DATA: begin mem[ptr] = sh; tsda = 1; end
                    default: tsda = 0;
                endcase
            end else if (bitcnt == 9) begin
                bitcnt = 0;
                tsda = 0;
                if (rd_pend) begin
                    rd_pend = 0;
                    rd_act = 1;
                    tsda = !txb[7];
                end else if (rd_act) begin
                    rd_act = 0;
                    ph = P_IDLE;
                end
            end else if (rd_act && bitcnt > 0) begin
                tsda = !txb[7 - bitcnt];
            end
        end
        pscl = cs;
        psda = cd;
    end

    task automatic issue(input bit r, input logic [6:0] a,
                         input logic [15:0] off, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input int extra);
        bit   ok;
        int   n;
        exp_t e;
        ok = (a == TGT);
        exp_bytes.push_back({a, 1'b0});
        if (ok) begin
            exp_bytes.push_back(off[15:8]);
            exp_bytes.push_back(off[7:0]);
            exp_bytes.push_back(r ? {a, 1'b1} : wd);
        end
        n = !ok ? 11 : (r ? 48 : 38);
        @(negedge clk);
        start = 1; rw = r; dev_addr = a; offset = off; wdata = wd;
        @(negedge clk);
        start = 0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        e.ack = !ok;
        e.rd  = exp_rd;
        e.t   = cyc + 1 + BT * n + extra;
        exp_done.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ack_err", {31'd0, ack_err}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        rst = 0;
        @(negedge clk);

        issue(0, 7'h36, 16'h1234, 8'hA5, 8'h00, 0);
        wait_done(2000);
        check("mem_1234", {24'd0, mem[16'h1234]}, 32'hA5);

        mem[16'h1234] = 8'h5A;
        issue(1, 7'h36, 16'h1234, 8'h00, 8'h5A, 0);
        wait_done(2000);

        issue(0, 7'h35, 16'h1234, 8'hEE, 8'h5A, 0);
        wait_done(2000);
        check("mem_absent", {24'd0, mem[16'h1234]}, 32'h5A);

        fork
            begin
                repeat (3) @(negedge scl_oe);
                stretch = 1;
                repeat (37) @(posedge clk);
                #1 stretch = 0;
            end
        join_none
        issue(0, 7'h36, 16'h0042, 8'h3C, 8'h5A, 37);
        wait_done(2000);
        check("mem_stretch", {24'd0, mem[16'h0042]}, 32'h3C);

        issue(0, 7'h36, 16'h0100, 8'h11, 8'h5A, 0);
        repeat (100) @(negedge clk);
        start = 1; rw = 1; dev_addr = 7'h36; offset = 16'h0042;
        @(negedge clk);
        start = 0;
        wait_done(2000);
        start = 1; rw = 0; dev_addr = 7'h36; offset = 16'h0777;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        check("busy_ignored", {31'd0, busy}, 32'd0);
        check("mem_0100", {24'd0, mem[16'h0100]}, 32'h11);

        issue(1, 7'h36, 16'h0100, 8'h00, 8'h11, 0);
        wait_done(2000);

        @(negedge clk);
        start = 1; rw = 0; dev_addr = 7'h36;
        offset = 16'h0300; wdata = 8'h99;
        @(negedge clk);
        start = 0;
        repeat (83) @(negedge clk);
        #2 rst = 1;
        #1;
        check("arst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("arst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        check("arst_rdata", {24'd0, rdata}, 32'd0);
        @(negedge clk);

        issue(0, 7'h36, 16'h0200, 8'h77, 8'h00, 0);
        wait_done(2000);
        check("mem_0200", {24'd0, mem[16'h0200]}, 32'h77);

        repeat (10) @(negedge clk);
        check("bytes_left", exp_bytes.size(), 32'd0);
        check("dones_left", exp_done.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
